// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/icache_pkg.sv
// Width helpers, address-split functions and FSM state encoding for icache_dm.
package icache_pkg;

    typedef logic [0:0] icstate_t;
    localparam icstate_t IDLE = 1'b0;
    localparam icstate_t FILL = 1'b1;

    function automatic int unsigned calc_idxw(int unsigned nsets);
        return $clog2(nsets);
    endfunction

    function automatic int unsigned calc_bofw(int unsigned blkwords);
        return $clog2(blkwords);
    endfunction

    function automatic int unsigned calc_tagw(int unsigned nsets, int unsigned blkwords);
        return 32 - 2 - calc_idxw(nsets) - calc_bofw(blkwords);
    endfunction

    // Address split: {tag, index, block offset, byte offset}.
    function automatic logic [31:0] addr_bof(logic [31:0] addr, int unsigned blkwords);
        return (addr >> 2) & (blkwords - 1);
    endfunction

    function automatic logic [31:0] addr_idx(logic [31:0] addr, int unsigned nsets,
                                             int unsigned blkwords);
        return (addr >> (2 + calc_bofw(blkwords))) & (nsets - 1);
    endfunction

    function automatic logic [31:0] addr_tag(logic [31:0] addr, int unsigned nsets,
                                             int unsigned blkwords);
        return addr >> (2 + calc_bofw(blkwords) + calc_idxw(nsets));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; cleared only by reset.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with multi-word block fill,
// full invalidate and saturating hit/miss counters.
module icache_dm
    import cpu_types_pkg::*;
    import icache_pkg::*;
#(
    parameter int unsigned NSETS    = 16,
    parameter int unsigned BLKWORDS = 2,
    parameter int unsigned CNTW     = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            imemREN,
    input  logic [31:0]     imemaddr,
    input  logic            invalidate,
    output logic            ihit,
    output word_t           imemload,
    output logic            iREN,
    output logic [31:0]     iaddr,
    input  logic            iwait,
    input  word_t           iload,
    output logic [CNTW-1:0] hit_count,
    output logic [CNTW-1:0] miss_count
);

    localparam int unsigned IDXW = calc_idxw(NSETS);
    localparam int unsigned BOFW = calc_bofw(BLKWORDS);
    localparam int unsigned TAGW = calc_tagw(NSETS, BLKWORDS);
    localparam int unsigned CW   = (BOFW > 0) ? BOFW : 1;

    icstate_t         state_q, state_d;
    logic [NSETS-1:0] valid_q, valid_d;
    logic             pend_q, pend_d;
    logic [CW-1:0]    fcnt_q, fcnt_d;
    logic [TAGW-1:0]  ftag_q, ftag_d;
    logic [IDXW-1:0]  fidx_q, fidx_d;

    logic [TAGW-1:0]  tag_mem [NSETS];
    word_t            data_mem [NSETS][BLKWORDS];

    logic [TAGW-1:0]  req_tag;
    logic [IDXW-1:0]  req_idx;
    logic [CW-1:0]    req_bof;
    logic             lookup_hit;
    logic             miss;
    logic             fill_we;
    logic             last_word;

    assign req_tag    = TAGW'(addr_tag(imemaddr, NSETS, BLKWORDS));
    assign req_idx    = IDXW'(addr_idx(imemaddr, NSETS, BLKWORDS));
    assign req_bof    = CW'(addr_bof(imemaddr, BLKWORDS));
    assign lookup_hit = imemREN && valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign last_word  = (fcnt_q == CW'(BLKWORDS - 1));
    assign fill_we    = (state_q == FILL) && !iwait;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        pend_d   = pend_q;
        fcnt_d   = fcnt_q;
        ftag_d   = ftag_q;
        fidx_d   = fidx_q;
        miss     = 1'b0;
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;

        if (invalidate) begin
            valid_d = '0;
        end

        case (state_q)
            IDLE: begin
                ihit = lookup_hit;
                if (lookup_hit) begin
                    imemload = data_mem[req_idx][req_bof];
                end
                if (imemREN && !lookup_hit) begin
                    miss    = 1'b1;
                    ftag_d  = req_tag;
                    fidx_d  = req_idx;
                    fcnt_d  = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = (32'({ftag_q, fidx_q}) << (BOFW + 2)) | (32'(fcnt_q) << 2);
                if (invalidate) begin
                    pend_d = 1'b1;
                end
                if (!iwait) begin
                    fcnt_d = fcnt_q + CW'(1);
                    if (last_word) begin
                        state_d = IDLE;
                        pend_d  = 1'b0;
                        // An invalidate seen at any point of the fill leaves the block invalid.
                        if (!pend_q && !invalidate) begin
                            valid_d[fidx_q] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            valid_q <= '0;
            pend_q  <= 1'b0;
            fcnt_q  <= '0;
            ftag_q  <= '0;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            fcnt_q  <= fcnt_d;
            ftag_q  <= ftag_d;
            fidx_q  <= fidx_d;
        end
    end

    // Storage arrays need no reset; valid bits gate every read.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            data_mem[fidx_q][fcnt_q] <= iload;
            if (last_word) begin
                tag_mem[fidx_q] <= ftag_q;
            end
        end
    end

    sat_counter #(
        .WIDTH(CNTW)
    ) u_hit_cnt (
        .clk  (CLK),
        .rst  (RST),
        .en   (ihit),
        .count(hit_count)
    );

    sat_counter #(
        .WIDTH(CNTW)
    ) u_miss_cnt (
        .clk  (CLK),
        .rst  (RST),
        .en   (miss),
        .count(miss_count)
    );

endmodule
